// File: rtl/audioqsys_switch_debouncer.sv
// rtl/audioqsys_switch_debouncer.sv - two-flop sync plus per-bit tick-qualified debounce with edge pulses
`timescale 1ns/1ps
module audioqsys_switch_debouncer #(
   parameter int WIDTH        = 18,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_TICKS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0]         sync1_q, sync2_q;
   logic [PW-1:0]            presc_q, presc_d;
   logic                     tick;
   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]         clean_q, clean_d;
   logic [WIDTH-1:0]         rise_q, rise_d;
   logic [WIDTH-1:0]         fall_q, fall_d;
   logic                     changed_q, changed_d;

   // Free-running prescaler; the tick is its terminal count, shared by every bit.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Per-bit qualification: a mismatch must survive STABLE_TICKS ticks before the level is taken.
   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
               clean_d[i] = sync2_q[i];
               cnt_d[i]   = '0;
               rise_d[i]  = sync2_q[i];
               fall_d[i]  = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   // State registers; reset clears everything so physically-high switches re-qualify as rises.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         presc_q   <= '0;
         cnt_q     <= '0;
         clean_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= sw_raw;
         sync2_q   <= sync1_q;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign sw_clean   = clean_q;
   assign sw_rise    = rise_q;
   assign sw_fall    = fall_q;
   assign sw_changed = changed_q;

endmodule

// File: doc/audioqsys_switch_debouncer.md
# audioqsys_switch_debouncer

Conditions the 18 raw slide-switch inputs from the board pins before they reach the switches PIO `in_port`. Each bit passes through a two-flop synchronizer and then a per-bit debounce filter clocked by a shared prescaler tick. The block outputs a clean level vector plus one-cycle rise, fall and any-change pulses for downstream edge-capture or interrupt logic.

## Interface

**Parameters**
- `WIDTH`, 18: number of switch bits.
- `TICK_DIV`, 50000: clk cycles per debounce tick; 1 ms at 50 MHz. Legal range is 2 or more.
- `STABLE_TICKS`, 10: consecutive ticks a bit must hold its new value before the output updates. Legal range is 2 to 255.

**Ports** (one clock, clk; reset is asynchronous and active-high, named reset)
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sw_raw` in WIDTH: asynchronous switch pins.
- `sw_clean` out WIDTH: debounced level vector; drives the PIO `in_port`.
- `sw_rise` out WIDTH: one-cycle pulse per bit on a debounced 0→1 transition.
- `sw_fall` out WIDTH: one-cycle pulse per bit on a debounced 1→0 transition.
- `sw_changed` out 1: one-cycle pulse when any bit of `sw_clean` updates.

## Operation

**Synchronizer**
- Each cycle, `sync1 <= sw_raw` and `sync2 <= sync1`.
- Only `sync2` is used downstream.

**Prescaler**
- `presc` is a free-running counter, 0 to TICK_DIV-1, that wraps to 0.
- `tick` = (`presc` == TICK_DIV-1). It is combinational and shared by all bits.

**Per-bit filter**, with counter `cnt[i]` of width ceil(log2(STABLE_TICKS)):
- If `sync2[i]` == `sw_clean[i]`: `cnt[i] <= 0`. Any bounce back to the old value restarts the qualification.
- Else, if `tick` and `cnt[i]` == STABLE_TICKS-1: `sw_clean[i] <= sync2[i]` and `cnt[i] <= 0`.
- Else, if `tick`: `cnt[i] <= cnt[i]+1`.
- Else: `cnt[i]` holds.

**Edge pulses** (registered, in the same cycle that `sw_clean[i]` updates)
- `sw_rise[i]` = 1 when the bit goes 0→1.
- `sw_fall[i]` = 1 when the bit goes 1→0.
- `sw_changed` = OR of all per-bit updates.
- All pulses are 0 in every other cycle.

**Simultaneous events**
- Bits are fully independent. Several bits may update in the same cycle; `sw_changed` is then a single pulse and every affected rise/fall bit is set.

**Reset** (asynchronous, at any time including mid-qualification)
- `sync1`, `sync2`, `presc`, every `cnt`, `sw_clean`, `sw_rise`, `sw_fall` and `sw_changed` go to 0.
- After reset, switches that are physically high qualify normally and produce a rise pulse.

## Timing

- **Reset values:** all outputs are 0.
- **Synchronizer latency:** 2 clk from a `sw_raw` change to `sync2`.
- **Filter latency:** from the first cycle `sync2[i]` differs from `sw_clean[i]`, the update lands between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles later. The exact value depends on prescaler phase.
- **Suppressed bounces:** a level that does not persist through STABLE_TICKS ticks never reaches the output.
- **Pulse width:** each pulse is exactly 1 clk.
- **Throughput:** each bit can change at most once per STABLE_TICKS ticks.
- **Counter wrap:** the prescaler wraps silently. `cnt` never exceeds STABLE_TICKS-1.

## Test plan

All scenarios use TICK_DIV=4 and STABLE_TICKS=3.

1. **Reset state:** assert reset while `sw_raw`=18'h3FFFF, then release. Required: all outputs are 0 during reset. `sw_clean` becomes 18'h3FFFF within 2+12 cycles of release, with `sw_rise`=18'h3FFFF and `sw_changed`=1 for 1 cycle.
2. **Clean step:** set `sw_raw[0]` 0→1 and hold. Required: `sw_clean[0]` rises 11 to 14 cycles later. `sw_rise[0]` pulses once; `sw_fall` stays 0.
3. **Bounce rejection:** toggle `sw_raw[5]` high for 6 cycles, then low for 2, repeating 5 times, then leave it low. Required: `sw_clean[5]` stays 0 and no pulses occur.
4. **Multi-bit simultaneous:** step `sw_raw` from 0 to 18'h20001 in one cycle. Required: both bits update in the same cycle, `sw_rise`=18'h20001, and `sw_changed` is a single 1-cycle pulse.
5. **Fall edge:** with `sw_clean[17]`=1, drop `sw_raw[17]` to 0. Required: `sw_fall[17]` pulses 1 cycle and `sw_clean[17]`=0. Latency bounds are as in scenario 2.
6. **Reset mid-qualification:** assert reset 7 cycles after a `sw_raw[3]` rise, then release with the input still high. Required: all outputs are 0 during reset. The full qualification restarts (9 to 12 cycles post-sync), with no early update.
